// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage with a single-outstanding imem
// request FSM (REQ/WAIT/HOLD), a one-word hold buffer for responses that
// arrive during a stall, and the IF/ID pipeline register.
// Optional feature: define FETCH_PERF_CNT_EN to add the stall_cnt and
// flush_cnt performance counter ports.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        pc_wren,
  input  logic        IFID_wren,
  input  logic        IFID_clear,
  input  logic        EXMEM_pcsel,
  input  logic        EXMEM_is_br,
  input  logic        EXMEM_is_uncbr,
  input  logic [31:0] EXMEM_alu_data,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IFID_pc,
  output logic [31:0] IFID_instr,
  output logic        IFID_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic        discard;
  logic [31:0] hold_buf;

  logic        redirect;
  logic        accept;
  logic        deliver;
  logic [31:0] deliver_word;
  logic [31:0] redirect_pc;

  // A taken branch or jump resolved in EX/MEM steers fetch to the target.
  assign redirect    = EXMEM_pcsel && (EXMEM_is_br || EXMEM_is_uncbr);
  assign accept      = pc_wren && IFID_wren && !IFID_clear && !redirect;
  assign redirect_pc = EXMEM_alu_data & 32'hFFFF_FFFC;

  // Request goes out only in REQ, and never while reset is held.
  assign imem_req  = (state == S_REQ) && !i_reset;
  assign imem_addr = pc;

  // Pick the word handed to IF/ID this cycle: live response or buffered one.
  always_comb begin
    deliver      = 1'b0;
    deliver_word = imem_rdata;
    case (state)
      S_WAIT: deliver = imem_rvalid && !discard && accept;
      S_HOLD: begin
        deliver      = accept;
        deliver_word = hold_buf;
      end
      default: ;
    endcase
  end

  // Fetch FSM, PC and stale-response tracking.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state   <= S_REQ;
      pc      <= RESET_PC;
      discard <= 1'b0;
    end else begin
      if (redirect) begin
        pc <= redirect_pc;
      end else if (deliver) begin
        pc <= pc + 32'd4;
      end

      case (state)
        S_REQ: begin
          if (imem_gnt) begin
            state   <= S_WAIT;
            // A redirect in the grant cycle makes this response stale.
            discard <= redirect;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            if (discard) begin
              discard <= 1'b0;
              state   <= S_REQ;
            end else if (redirect || accept) begin
              state <= S_REQ;
            end else begin
              state <= S_HOLD;
            end
          end else if (redirect) begin
            discard <= 1'b1;
          end
        end
        S_HOLD: begin
          if (redirect || accept) begin
            state <= S_REQ;
          end
        end
        default: state <= S_REQ;
      endcase
    end
  end

  // Hold buffer captures a response that arrives while the pipe is stalled.
  always_ff @(posedge i_clk) begin
    if (state == S_WAIT && imem_rvalid && !discard && !redirect && !accept) begin
      hold_buf <= imem_rdata;
    end
  end

  // IF/ID boundary: clear beats load, load beats bubble, otherwise hold.
  always_ff @(posedge i_clk) begin
    if (i_reset || IFID_clear) begin
      IFID_instr <= NOP_INSTR;
      IFID_pc    <= 32'h0000_0000;
      IFID_valid <= 1'b0;
    end else if (deliver) begin
      IFID_instr <= deliver_word;
      IFID_pc    <= pc;
      IFID_valid <= 1'b1;
    end else if (IFID_wren) begin
      IFID_instr <= NOP_INSTR;
      IFID_valid <= 1'b0;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // Free-running stall and flush event counters, wrapping modulo 2^32.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      stall_cnt <= 32'h0000_0000;
      flush_cnt <= 32'h0000_0000;
    end else begin
      if (!IFID_wren) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (redirect) begin
        flush_cnt <= flush_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed vector table, a reset-abandon sequence, and a
// randomized run against a transaction-level reference model of fetch.
module tb_fetch_stage;

  localparam logic [31:0] RPC = 32'h0000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        pcw, ifw, clr, pcsel, br, uncbr;
  logic [31:0] tgt;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        gnt, rv;
  logic [31:0] rdata;
  logic [31:0] IFID_pc, IFID_instr;
  logic        IFID_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(RPC), .NOP_INSTR(NOP)) dut (
    .i_clk(clk), .i_reset(rst), .pc_wren(pcw), .IFID_wren(ifw), .IFID_clear(clr),
    .EXMEM_pcsel(pcsel), .EXMEM_is_br(br), .EXMEM_is_uncbr(uncbr), .EXMEM_alu_data(tgt),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(gnt), .imem_rvalid(rv),
    .imem_rdata(rdata), .IFID_pc(IFID_pc), .IFID_instr(IFID_instr), .IFID_valid(IFID_valid)
`ifdef FETCH_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  task automatic chk1(input string n, input logic a, input logic e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %b expected %b", n, a, e);
    end
  endtask

  task automatic chk32(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  // c = {pc_wren, IFID_wren, IFID_clear, redirect kind[1:0], gnt, rvalid}
  // redirect kind: 0 none, 1 branch, 2 jump, 3 pcsel without branch flags
  // ef = {expected imem_req, expected IFID_valid}
  typedef struct {
    logic [6:0]  c;
    logic [31:0] tgt;
    logic [31:0] rd;
    logic [1:0]  ef;
    logic [31:0] ea;
    logic [31:0] ei;
    logic [31:0] ep;
  } vec_t;

  function automatic vec_t v(input logic [6:0] c, input logic [31:0] t, input logic [31:0] d,
                             input logic [1:0] ef, input logic [31:0] ea,
                             input logic [31:0] ei, input logic [31:0] ep);
    vec_t r;
    r.c = c; r.tgt = t; r.rd = d; r.ef = ef; r.ea = ea; r.ei = ei; r.ep = ep;
    return r;
  endfunction

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[15:0]};
  endfunction

  task automatic idle();
    pcw = 1'b1; ifw = 1'b1; clr = 1'b0; pcsel = 1'b0; br = 1'b0; uncbr = 1'b0;
    tgt = 32'h0; gnt = 1'b0; rv = 1'b0; rdata = 32'h0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk1("reset imem_req", imem_req, 1'b0);
    chk1("reset IFID_valid", IFID_valid, 1'b0);
    chk32("reset IFID_instr", IFID_instr, NOP);
    chk32("reset IFID_pc", IFID_pc, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    chk32("reset stall_cnt", stall_cnt, 32'h0);
    chk32("reset flush_cnt", flush_cnt, 32'h0);
`endif
    rst = 1'b0;
    #1;
    chk1("post-reset imem_req", imem_req, 1'b1);
    chk32("post-reset imem_addr", imem_addr, RPC);
  endtask

  // Reference model: tracks the fetch as transactions (outstanding request,
  // whether its answer is stale, word in hand) rather than FSM states.
  logic        m_out, m_drop, m_buf;
  logic [31:0] m_bw, m_pc, m_ipc, m_iinstr;
  logic        m_iv;
  logic [31:0] m_stall, m_flush;

  task automatic model_init();
    m_out = 1'b0; m_drop = 1'b0; m_buf = 1'b0; m_bw = 32'h0;
    m_pc = RPC; m_ipc = 32'h0; m_iinstr = NOP; m_iv = 1'b0;
    m_stall = 32'h0; m_flush = 32'h0;
  endtask

  task automatic model_step();
    logic redir, acc, have, load, issue;
    logic [31:0] w;
    redir = pcsel && (br || uncbr);
    acc   = pcw && ifw && !clr && !redir;
    issue = !m_out && !m_buf && gnt;
    have  = 1'b0;
    w     = 32'h0;
    if (m_buf) begin
      have = 1'b1;
      w    = m_bw;
    end else if (m_out && rv) begin
      m_out = 1'b0;
      if (m_drop) m_drop = 1'b0;
      else begin
        have = 1'b1;
        w    = rdata;
      end
    end else if (m_out && redir) begin
      m_drop = 1'b1;
    end
    load  = have && acc;
    m_buf = have && !acc && !redir;
    if (m_buf) m_bw = w;
    if (issue) begin
      m_out  = 1'b1;
      m_drop = redir;
    end
    if (clr) begin
      m_iinstr = NOP; m_ipc = 32'h0; m_iv = 1'b0;
    end else if (load) begin
      m_iinstr = w; m_ipc = m_pc; m_iv = 1'b1;
    end else if (ifw) begin
      m_iinstr = NOP; m_iv = 1'b0;
    end
    if (redir) m_pc = {tgt[31:2], 2'b00};
    else if (load) m_pc = m_pc + 32'd4;
    if (!ifw) m_stall = m_stall + 32'd1;
    if (redir) m_flush = m_flush + 32'd1;
  endtask

  vec_t tbl[34];
  int exp_stall, exp_flush;

  logic        resp_pend;
  int          resp_dly;
  logic [31:0] resp_data;
  logic        req_now;
  logic [31:0] addr_now;

  initial begin
    tbl[0]  = v(7'b1100001, 32'h0,        32'hDEADBEEF, 2'b10, 32'h0,        NOP,          32'h0);
    tbl[1]  = v(7'b1100010, 32'h0,        32'h0,        2'b00, 32'h0,        NOP,          32'h0);
    tbl[2]  = v(7'b1100011, 32'h0,        32'h00500093, 2'b11, 32'h4,        32'h00500093, 32'h0);
    tbl[3]  = v(7'b1100010, 32'h0,        32'h0,        2'b00, 32'h4,        NOP,          32'h0);
    tbl[4]  = v(7'b1100011, 32'h0,        32'h00500093, 2'b11, 32'h8,        32'h00500093, 32'h4);
    tbl[5]  = v(7'b1100010, 32'h0,        32'h0,        2'b00, 32'h8,        NOP,          32'h4);
    tbl[6]  = v(7'b0000011, 32'h0,        32'h00A00113, 2'b00, 32'h8,        NOP,          32'h4);
    tbl[7]  = v(7'b0000010, 32'h0,        32'h0,        2'b00, 32'h8,        NOP,          32'h4);
    tbl[8]  = v(7'b0000010, 32'h0,        32'h0,        2'b00, 32'h8,        NOP,          32'h4);
    tbl[9]  = v(7'b1100010, 32'h0,        32'h0,        2'b11, 32'hC,        32'h00A00113, 32'h8);
    tbl[10] = v(7'b1100010, 32'h0,        32'h0,        2'b00, 32'hC,        NOP,          32'h8);
    tbl[11] = v(7'b1100110, 32'h101,      32'h0,        2'b00, 32'h100,      NOP,          32'h8);
    tbl[12] = v(7'b1100001, 32'h0,        32'h11111111, 2'b10, 32'h100,      NOP,          32'h8);
    tbl[13] = v(7'b1101010, 32'h200,      32'h0,        2'b00, 32'h200,      NOP,          32'h8);
    tbl[14] = v(7'b1100001, 32'h0,        32'h22222222, 2'b10, 32'h200,      NOP,          32'h8);
    tbl[15] = v(7'b1100010, 32'h0,        32'h0,        2'b00, 32'h200,      NOP,          32'h8);
    tbl[16] = v(7'b1100001, 32'h0,        32'h00300193, 2'b11, 32'h204,      32'h00300193, 32'h200);
    tbl[17] = v(7'b1100010, 32'h0,        32'h0,        2'b00, 32'h204,      NOP,          32'h200);
    tbl[18] = v(7'b1110001, 32'h0,        32'h00400213, 2'b00, 32'h204,      NOP,          32'h0);
    tbl[19] = v(7'b1100000, 32'h0,        32'h0,        2'b11, 32'h208,      32'h00400213, 32'h204);
    tbl[20] = v(7'b1100010, 32'h0,        32'h0,        2'b00, 32'h208,      NOP,          32'h204);
    tbl[21] = v(7'b0100001, 32'h0,        32'h00000055, 2'b00, 32'h208,      NOP,          32'h204);
    tbl[22] = v(7'b1100100, 32'h303,      32'h0,        2'b10, 32'h300,      NOP,          32'h204);
    tbl[23] = v(7'b1100100, 32'h400,      32'h0,        2'b10, 32'h400,      NOP,          32'h204);
    tbl[24] = v(7'b1101100, 32'h800,      32'h0,        2'b10, 32'h400,      NOP,          32'h204);
    tbl[25] = v(7'b1100010, 32'h0,        32'h0,        2'b00, 32'h400,      NOP,          32'h204);
    tbl[26] = v(7'b1100101, 32'h500,      32'h00000066, 2'b10, 32'h500,      NOP,          32'h204);
    tbl[27] = v(7'b1100010, 32'h0,        32'h0,        2'b00, 32'h500,      NOP,          32'h204);
    tbl[28] = v(7'b1100000, 32'h0,        32'h0,        2'b00, 32'h500,      NOP,          32'h204);
    tbl[29] = v(7'b1100001, 32'h0,        32'h00600293, 2'b11, 32'h504,      32'h00600293, 32'h500);
    tbl[30] = v(7'b1000000, 32'h0,        32'h0,        2'b11, 32'h504,      32'h00600293, 32'h500);
    tbl[31] = v(7'b1100100, 32'hFFFFFFFF, 32'h0,        2'b10, 32'hFFFFFFFC, NOP,          32'h500);
    tbl[32] = v(7'b1100010, 32'h0,        32'h0,        2'b00, 32'hFFFFFFFC, NOP,          32'h500);
    tbl[33] = v(7'b1100001, 32'h0,        32'h00700313, 2'b11, 32'h0,        32'h00700313, 32'hFFFFFFFC);

    rst = 1'b1;
    idle();
    do_reset();

    // Directed table from reset.
    exp_stall = 0;
    exp_flush = 0;
    for (int i = 0; i < 34; i++) begin
      pcw   = tbl[i].c[6];
      ifw   = tbl[i].c[5];
      clr   = tbl[i].c[4];
      pcsel = (tbl[i].c[3:2] != 2'd0);
      br    = (tbl[i].c[3:2] == 2'd1);
      uncbr = (tbl[i].c[3:2] == 2'd2);
      gnt   = tbl[i].c[1];
      rv    = tbl[i].c[0];
      tgt   = tbl[i].tgt;
      rdata = tbl[i].rd;
      if (!ifw) exp_stall++;
      if (br || uncbr) exp_flush++;
      @(posedge clk);
      #1;
      chk1($sformatf("row%0d imem_req", i), imem_req, tbl[i].ef[1]);
      chk32($sformatf("row%0d imem_addr", i), imem_addr, tbl[i].ea);
      chk1($sformatf("row%0d IFID_valid", i), IFID_valid, tbl[i].ef[0]);
      chk32($sformatf("row%0d IFID_instr", i), IFID_instr, tbl[i].ei);
      chk32($sformatf("row%0d IFID_pc", i), IFID_pc, tbl[i].ep);
    end
`ifdef FETCH_PERF_CNT_EN
    chk32("table stall_cnt", stall_cnt, 32'(exp_stall));
    chk32("table flush_cnt", flush_cnt, 32'(exp_flush));
`endif

    // Reset with a request outstanding; rvalid in the first cycle after is ignored.
    idle();
    gnt = 1'b1;
    @(posedge clk);
    #1;
    chk1("abandon granted req", imem_req, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk1("abandon reset imem_req", imem_req, 1'b0);
    chk1("abandon reset IFID_valid", IFID_valid, 1'b0);
    chk32("abandon reset IFID_pc", IFID_pc, 32'h0);
    rst = 1'b0;
    gnt = 1'b0;
    rv = 1'b1;
    rdata = 32'hBADBAD00;
    #1;
    chk1("abandon first imem_req", imem_req, 1'b1);
    chk32("abandon first imem_addr", imem_addr, RPC);
    @(posedge clk);
    #1;
    chk1("abandon stale IFID_valid", IFID_valid, 1'b0);
    chk32("abandon stale IFID_instr", IFID_instr, NOP);
    chk1("abandon stale imem_req", imem_req, 1'b1);
    rv = 1'b0;
    gnt = 1'b1;
    @(posedge clk);
    #1;
    gnt = 1'b0;
    rv = 1'b1;
    rdata = 32'h00800393;
    @(posedge clk);
    #1;
    chk1("abandon fresh IFID_valid", IFID_valid, 1'b1);
    chk32("abandon fresh IFID_instr", IFID_instr, 32'h00800393);
    chk32("abandon fresh IFID_pc", IFID_pc, RPC);
    chk32("abandon fresh imem_addr", imem_addr, RPC + 32'd4);

    // Randomized traffic against the reference model.
    do_reset();
    model_init();
    resp_pend = 1'b0;
    resp_dly  = 0;
    resp_data = 32'h0;
    for (int c = 0; c < 3000; c++) begin
      rv    = resp_pend && (resp_dly == 0);
      rdata = rv ? resp_data : $urandom;
      gnt   = ($urandom % 4) != 0;
      pcw   = ($urandom % 6) != 0;
      ifw   = ($urandom % 6) != 0;
      clr   = ($urandom % 16) == 0;
      pcsel = ($urandom % 8) == 0;
      br    = ($urandom % 2) == 1;
      uncbr = ($urandom % 2) == 1;
      tgt   = $urandom;
      req_now  = imem_req;
      addr_now = imem_addr;
      model_step();
      @(posedge clk);
      #1;
      if (rv) resp_pend = 1'b0;
      else if (resp_pend) resp_dly--;
      if (req_now && gnt) begin
        resp_pend = 1'b1;
        resp_dly  = int'($urandom % 3);
        resp_data = mem(addr_now);
      end
      chk1($sformatf("rnd%0d imem_req", c), imem_req, !m_out && !m_buf);
      chk32($sformatf("rnd%0d imem_addr", c), imem_addr, m_pc);
      chk1($sformatf("rnd%0d IFID_valid", c), IFID_valid, m_iv);
      chk32($sformatf("rnd%0d IFID_instr", c), IFID_instr, m_iinstr);
      chk32($sformatf("rnd%0d IFID_pc", c), IFID_pc, m_ipc);
    end
`ifdef FETCH_PERF_CNT_EN
    chk32("random stall_cnt", stall_cnt, m_stall);
    chk32("random flush_cnt", flush_cnt, m_flush);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
